// File: rtl/cond_pkg.sv
// Condition codes, flag bit positions and flag-write selects
// shared by the condition unit and its checkers.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-field evaluator against an NZCV value.
// Shared with the branch predictor checker.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register, execute-stage write gating
// and saturating executed/squashed debug counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_w_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  input  logic             cnt_clr_i,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             cond_ex_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;
  logic             pass;
  logic             commit;
  logic             upd;

  cond_check u_check (
    .cond  (cond_i),
    .flags (flags_q),
    .pass  (pass)
  );

  assign cond_ex_o   = valid_i & pass;
  assign commit      = valid_i & ~stall_i;
  assign upd         = commit & cond_ex_o;
  assign pc_src_o    = upd & pcs_i;
  assign reg_write_o = upd & reg_w_i & ~no_write_i;
  assign mem_write_o = upd & mem_w_i;

  // No bypass: the condition always sees the pre-update register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (upd) begin
      if (flag_w_i[FLAGW_NZ]) begin
        flags_q[FLAG_N] <= alu_flags_i[FLAG_N];
        flags_q[FLAG_Z] <= alu_flags_i[FLAG_Z];
      end
      if (flag_w_i[FLAGW_CV]) begin
        flags_q[FLAG_C] <= alu_flags_i[FLAG_C];
        flags_q[FLAG_V] <= alu_flags_i[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (cnt_clr_i) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (commit) begin
      if (cond_ex_o) begin
        if (~&exec_q) exec_q <= exec_q + 1'b1;
      end else begin
        if (~&squash_q) squash_q <= squash_q + 1'b1;
      end
    end
  end

  assign flags_o      = flags_q;
  assign exec_cnt_o   = exec_q;
  assign squash_cnt_o = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed + random bench for cond_unit with a scoreboard queue
// of expected gated outputs and a reference NZCV/counter model.
module tb_cond_unit;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic pc;
    logic rw;
    logic mw;
    logic cex;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic             stall_i;
  logic [3:0]       cond_i;
  logic [1:0]       flag_w_i;
  logic [3:0]       alu_flags_i;
  logic             pcs_i;
  logic             reg_w_i;
  logic             mem_w_i;
  logic             no_write_i;
  logic             cnt_clr_i;
  logic             pc_src_o;
  logic             reg_write_o;
  logic             mem_write_o;
  logic             cond_ex_o;
  logic [3:0]       flags_o;
  logic [CNT_W-1:0] exec_cnt_o;
  logic [CNT_W-1:0] squash_cnt_o;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .stall_i      (stall_i),
    .cond_i       (cond_i),
    .flag_w_i     (flag_w_i),
    .alu_flags_i  (alu_flags_i),
    .pcs_i        (pcs_i),
    .reg_w_i      (reg_w_i),
    .mem_w_i      (mem_w_i),
    .no_write_i   (no_write_i),
    .cnt_clr_i    (cnt_clr_i),
    .pc_src_o     (pc_src_o),
    .reg_write_o  (reg_write_o),
    .mem_write_o  (mem_write_o),
    .cond_ex_o    (cond_ex_o),
    .flags_o      (flags_o),
    .exec_cnt_o   (exec_cnt_o),
    .squash_cnt_o (squash_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  exp_t sb_q[$];
  exp_t last_obs;
  logic [3:0] m_flags;
  logic [CNT_W-1:0] m_exec;
  logic [CNT_W-1:0] m_sq;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic mpass(input logic [3:0] c,
                                 input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    b = 1'b0;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic v, input logic st,
                      input logic [3:0] c, input logic [1:0] fw,
                      input logic [3:0] alu, input logic pcs,
                      input logic rw, input logic mw,
                      input logic nw, input logic clr);
    exp_t e, got;
    logic p, cm;
    valid_i = v; stall_i = st; cond_i = c; flag_w_i = fw;
    alu_flags_i = alu; pcs_i = pcs; reg_w_i = rw;
    mem_w_i = mw; no_write_i = nw; cnt_clr_i = clr;
    p  = v && mpass(c, m_flags);
    cm = v && !st;
    e.cex = p;
    e.pc  = cm && p && pcs;
    e.rw  = cm && p && rw && !nw;
    e.mw  = cm && p && mw;
    sb_q.push_back(e);
    #3;
    got = '{pc: pc_src_o, rw: reg_write_o, mw: mem_write_o,
            cex: cond_ex_o};
    last_obs = got;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      chk("gated_outs", {12'd0, got}, {12'd0, e});
    end
    @(posedge clk);
    if (cm && p) begin
      if (fw[1]) m_flags[3:2] = alu[3:2];
      if (fw[0]) m_flags[1:0] = alu[1:0];
    end
    if (clr) begin
      m_exec = '0;
      m_sq   = '0;
    end else if (cm) begin
      if (p) begin
        if (m_exec != CMAX) m_exec = m_exec + 1'b1;
      end else begin
        if (m_sq != CMAX) m_sq = m_sq + 1'b1;
      end
    end
    #1;
    chk("flags", {12'd0, flags_o}, {12'd0, m_flags});
    chk("exec_cnt", {14'd0, exec_cnt_o}, {14'd0, m_exec});
    chk("squash_cnt", {14'd0, squash_cnt_o}, {14'd0, m_sq});
  endtask

  task automatic set_flags(input logic [3:0] f);
    step(1, 0, 4'b1110, 2'b11, f, 0, 0, 0, 0, 0);
  endtask

  task automatic probe(input logic [3:0] c);
    step(1, 0, c, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_flags = '0; m_exec = '0; m_sq = '0;
    reset = 1'b1; valid_i = 0; stall_i = 0; cond_i = 0;
    flag_w_i = 0; alu_flags_i = 0; pcs_i = 0; reg_w_i = 0;
    mem_w_i = 0; no_write_i = 0; cnt_clr_i = 0;
    #2;
    chk("rst_flags", {12'd0, flags_o}, 16'd0);
    chk("rst_exec", {14'd0, exec_cnt_o}, 16'd0);
    chk("rst_squash", {14'd0, squash_cnt_o}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CMP then BEQ / BNE
    step(1, 0, 4'b1110, 2'b11, 4'b0110, 0, 1, 0, 1, 0);
    chk("cmp_regw", {15'd0, last_obs.rw}, 16'd0);
    chk("cmp_flags", {12'd0, flags_o}, 16'h6);
    probe(4'b0000);
    chk("beq_pc", {15'd0, last_obs.pc}, 16'd1);
    probe(4'b0001);
    chk("bne_pc", {15'd0, last_obs.pc}, 16'd0);
    chk("bne_squash", {14'd0, squash_cnt_o}, 16'd1);

    // Partial update: only C,V
    set_flags(4'b1001);
    step(1, 0, 4'b1110, 2'b01, 4'b0110, 0, 0, 0, 0, 0);
    chk("partial", {12'd0, flags_o}, 16'hA);

    // Failed condition blocks flag update and memory write
    step(1, 0, 4'b0000, 2'b11, 4'b0100, 0, 0, 1, 0, 0);
    chk("fail_flags", {12'd0, flags_o}, 16'hA);
    chk("fail_memw", {15'd0, last_obs.mw}, 16'd0);

    // Signed / unsigned codes
    set_flags(4'b1001);
    probe(4'b1010);
    chk("ge", {15'd0, last_obs.cex}, 16'd1);
    probe(4'b1011);
    chk("lt", {15'd0, last_obs.cex}, 16'd0);
    probe(4'b1100);
    chk("gt", {15'd0, last_obs.cex}, 16'd1);
    set_flags(4'b0010);
    probe(4'b1000);
    chk("hi", {15'd0, last_obs.cex}, 16'd1);
    set_flags(4'b0110);
    probe(4'b1001);
    chk("ls", {15'd0, last_obs.cex}, 16'd1);

    // Invalid instruction does nothing
    step(0, 0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
    chk("inv_outs", {12'd0, last_obs}, 16'd0);

    // Stall: no flag or counter change
    step(0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 1, 4'b1110, 2'b11, 4'b1001, 1, 1, 1, 0, 0);
    chk("stall_flags", {12'd0, flags_o}, 16'h6);
    chk("stall_exec", {14'd0, exec_cnt_o}, 16'd0);

    // Saturation and clear-with-commit
    for (int i = 0; i < 5; i++)
      step(1, 0, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 0);
    chk("exec_sat", {14'd0, exec_cnt_o}, 16'd3);
    step(1, 0, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 1);
    chk("clr_commit", {14'd0, exec_cnt_o}, 16'd0);

    // Random mix
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);

    // Asynchronous reset between edges
    set_flags(4'b1111);
    probe(4'b0001);
    valid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_flags", {12'd0, flags_o}, 16'd0);
    chk("arst_exec", {14'd0, exec_cnt_o}, 16'd0);
    chk("arst_squash", {14'd0, squash_cnt_o}, 16'd0);
    chk("arst_outs", {12'd0, pc_src_o, reg_write_o, mem_write_o,
                      cond_ex_o}, 16'd0);
    m_flags = '0; m_exec = '0; m_sq = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    probe(4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
